// File: rtl/updown_cntr_pkg.sv
// ============================================================================
// Module      : updown_cntr_pkg
// Description : Shared constants and the load-clamp helper for the
//               parametrised up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package updown_cntr_pkg;

    // Direction encoding on the 'up' input
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Bound behaviour selected by the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Limit a load value to the inclusive upper bound of the counter
    function automatic logic [31:0] clamp_ld(input logic [31:0] value,
                                             input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/updown_cntr_gen_sticky_flags.sv
// ============================================================================
// Module      : udc_sticky_flags
// Description : Set/clear register pair holding the overflow and underflow
//               flags of the up/down counter. A set event beats a clear in
//               the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udc_sticky_flags (
    input  logic clk,
    input  logic rst,
    input  logic clr_flg,
    input  logic set_ovf,
    input  logic set_unf,
    output logic ovf,
    output logic unf
);

    // Each flag is set by its event and held until cleared or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (set_ovf)      ovf <= 1'b1;
            else if (clr_flg) ovf <= 1'b0;

            if (set_unf)      unf <= 1'b1;
            else if (clr_flg) unf <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/updown_cntr_gen.sv
// ============================================================================
// Module      : updown_cntr_gen
// Description : Parametrised up/down counter with configurable width and
//               modulus, wrap or saturate at the bounds, synchronous load,
//               terminal-count and wrap-event outputs.
//               Optional macro UDC_STICKY_FLAGS_EN adds clr_flg input and
//               sticky ovf/unf outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_cntr_gen
    import updown_cntr_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int          SATURATE = 0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
`ifdef UDC_STICKY_FLAGS_EN
    input  logic             clr_flg,
    output logic             ovf,
    output logic             unf,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_C  = WIDTH'(RST_VAL);
    localparam logic             SAT_ON = (SATURATE == MODE_SAT);

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] ld_clamped;

    // '>=' so a misconfigured reset value above the bound still behaves as the top
    assign at_max     = (count >= MAX_C);
    assign at_zero    = (count == '0);
    assign ld_clamped = WIDTH'(clamp_ld(32'(ld_val), 32'(MAX_C)));

    // Terminal count depends only on the current count and direction
    assign tc = ((up == DIR_UP) && (count == MAX_C)) ||
                ((up == DIR_DN) && at_zero);

    // Counter core: reset beats load, load beats count enable
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_C;
            wrap  <= 1'b0;
        end else if (ld) begin
            count <= ld_clamped;
            wrap  <= 1'b0;
        end else if (en) begin
            wrap <= 1'b0;
            if (up == DIR_UP) begin
                if (!at_max) begin
                    count <= count + WIDTH'(1);
                end else if (!SAT_ON) begin
                    count <= '0;
                    wrap  <= 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count <= count - WIDTH'(1);
                end else if (!SAT_ON) begin
                    count <= MAX_C;
                    wrap  <= 1'b1;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

`ifdef UDC_STICKY_FLAGS_EN
    logic set_ovf;
    logic set_unf;

    // Bound hits on an enabled step; a load cycle never counts
    assign set_ovf = !ld && en && (up == DIR_UP) && at_max;
    assign set_unf = !ld && en && (up == DIR_DN) && at_zero;

    udc_sticky_flags u_flags (
        .clk     (clk),
        .rst     (rst),
        .clr_flg (clr_flg),
        .set_ovf (set_ovf),
        .set_unf (set_unf),
        .ovf     (ovf),
        .unf     (unf)
    );
`endif

    // Only meaningful when the bound is below the full register range
    if (64'(MAX_VAL) < ((64'd1 << WIDTH) - 64'd1)) begin : g_range_chk
        a_count_in_range: assert property (@(posedge clk) disable iff (rst)
                                           (count <= MAX_C));
    end

endmodule

`default_nettype wire

// File: tb/tb_updown_cntr_gen.sv
// ============================================================================
// Module      : tb_updown_cntr_gen
// Description : Directed self-checking bench for updown_cntr_gen: a wrapping
//               counter (MAX_VAL=9), a saturating one and a RST_VAL=3 one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_cntr_gen;

    logic       clk = 1'b0;
    logic       rst, en, up, ld;
    logic [3:0] ld_val;
    logic [3:0] count;
    logic       tc, wrap;

    logic       en_s, up_s, ld_s;
    logic [3:0] ld_val_s;
    logic [3:0] count_s;
    logic       tc_s, wrap_s;

    logic [3:0] count_r;
    logic       tc_r, wrap_r;

`ifdef UDC_STICKY_FLAGS_EN
    logic clr_flg;
    logic ovf, unf, ovf_s, unf_s, ovf_r, unf_r;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    updown_cntr_gen #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RST_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .ld_val(ld_val),
`ifdef UDC_STICKY_FLAGS_EN
        .clr_flg(clr_flg), .ovf(ovf), .unf(unf),
`endif
        .count(count), .tc(tc), .wrap(wrap)
    );

    updown_cntr_gen #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .RST_VAL(0)) dut_sat (
        .clk(clk), .rst(rst), .en(en_s), .up(up_s), .ld(ld_s), .ld_val(ld_val_s),
`ifdef UDC_STICKY_FLAGS_EN
        .clr_flg(clr_flg), .ovf(ovf_s), .unf(unf_s),
`endif
        .count(count_s), .tc(tc_s), .wrap(wrap_s)
    );

    updown_cntr_gen #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RST_VAL(3)) dut_r3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .ld_val(ld_val),
`ifdef UDC_STICKY_FLAGS_EN
        .clr_flg(clr_flg), .ovf(ovf_r), .unf(unf_r),
`endif
        .count(count_r), .tc(tc_r), .wrap(wrap_r)
    );

    // Advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; up = 1'b1; ld = 1'b0; ld_val = 4'd0;
        en_s = 1'b0; up_s = 1'b1; ld_s = 1'b0; ld_val_s = 4'd0;
`ifdef UDC_STICKY_FLAGS_EN
        clr_flg = 1'b0;
`endif
        step();
        step();
        rst = 1'b0; en = 1'b0;
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc_up got=%b exp=0", tc); end
        total++; if (count_r !== 4'd3) begin bad++; $display("FAIL reset_rstval3 got=%0d exp=3", count_r); end
        up = 1'b0;
        #1;
        total++; if (tc !== 1'b1) begin bad++; $display("FAIL reset_tc_dn got=%b exp=1", tc); end
        up = 1'b1;
        step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL idle_hold got=%0d exp=0", count); end
    endtask

    task automatic test_count_up();
        logic [3:0] exp_c;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_c = 4'((i + 1) % 10);
            total++; if (count !== exp_c) begin bad++; $display("FAIL up_count[%0d] got=%0d exp=%0d", i, count, exp_c); end
            total++; if (wrap !== (i == 9)) begin bad++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, wrap, (i == 9)); end
            total++; if (tc !== (exp_c == 4'd9)) begin bad++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, tc, (exp_c == 4'd9)); end
        end
        en = 1'b0;
    endtask

    task automatic test_count_down();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'd1, 4'd0, 4'd9, 4'd8};
        en = 1'b1; up = 1'b0;
        #1;
        total++; if (tc !== 1'b0) begin bad++; $display("FAIL dn_tc_start got=%b exp=0", tc); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (count !== exp_seq[i]) begin bad++; $display("FAIL dn_count[%0d] got=%0d exp=%0d", i, count, exp_seq[i]); end
            total++; if (wrap !== (i == 2)) begin bad++; $display("FAIL dn_wrap[%0d] got=%b exp=%b", i, wrap, (i == 2)); end
            total++; if (tc !== (exp_seq[i] == 4'd0)) begin bad++; $display("FAIL dn_tc[%0d] got=%b exp=%b", i, tc, (exp_seq[i] == 4'd0)); end
            if (i == 2) begin
                up = 1'b1;
                #1;
                total++; if (tc !== 1'b1) begin bad++; $display("FAIL dir_tc_up got=%b exp=1", tc); end
                up = 1'b0;
                #1;
                total++; if (tc !== 1'b0) begin bad++; $display("FAIL dir_tc_dn got=%b exp=0", tc); end
            end
        end
        en = 1'b0;
        step();
        total++; if (count !== 4'd8) begin bad++; $display("FAIL dn_hold got=%0d exp=8", count); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL dn_hold_wrap got=%b exp=0", wrap); end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
        ld_s = 1'b1; ld_val_s = 4'd7;
        step();
        ld_s = 1'b0; en_s = 1'b1; up_s = 1'b1;
        total++; if (count_s !== 4'd7) begin bad++; $display("FAIL sat_load got=%0d exp=7", count_s); end
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (count_s !== exp_seq[i]) begin bad++; $display("FAIL sat_up[%0d] got=%0d exp=%0d", i, count_s, exp_seq[i]); end
            total++; if (wrap_s !== 1'b0) begin bad++; $display("FAIL sat_up_wrap[%0d] got=%b exp=0", i, wrap_s); end
        end
        total++; if (tc_s !== 1'b1) begin bad++; $display("FAIL sat_tc got=%b exp=1", tc_s); end
        up_s = 1'b0;
        step();
        total++; if (count_s !== 4'd8) begin bad++; $display("FAIL sat_down got=%0d exp=8", count_s); end
        ld_s = 1'b1; ld_val_s = 4'd0;
        step();
        ld_s = 1'b0;
        step();
        total++; if (count_s !== 4'd0) begin bad++; $display("FAIL sat_floor got=%0d exp=0", count_s); end
        total++; if (wrap_s !== 1'b0) begin bad++; $display("FAIL sat_floor_wrap got=%b exp=0", wrap_s); end
        en_s = 1'b0;
    endtask

    task automatic test_load();
        ld = 1'b1; ld_val = 4'd13; en = 1'b1; up = 1'b1;
        step();
        total++; if (count !== 4'd9) begin bad++; $display("FAIL ld_clamp got=%0d exp=9", count); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL ld_clamp_wrap got=%b exp=0", wrap); end
        ld_val = 4'd5;
        step();
        total++; if (count !== 4'd5) begin bad++; $display("FAIL ld_value got=%0d exp=5", count); end
        ld = 1'b0;
        step();
        total++; if (count !== 4'd6) begin bad++; $display("FAIL ld_then_inc got=%0d exp=6", count); end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; en = 1'b1; up = 1'b1; ld = 1'b1; ld_val = 4'd2;
        step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_mid got=%0d exp=0", count); end
        total++; if (count_r !== 4'd3) begin bad++; $display("FAIL rst_mid_r3 got=%0d exp=3", count_r); end
        rst = 1'b0; ld = 1'b0;
        step();
        total++; if (count !== 4'd1) begin bad++; $display("FAIL rst_resume got=%0d exp=1", count); end
        total++; if (count_r !== 4'd4) begin bad++; $display("FAIL rst_resume_r3 got=%0d exp=4", count_r); end
        en = 1'b0;
    endtask

`ifdef UDC_STICKY_FLAGS_EN
    task automatic test_flags();
        rst = 1'b1; step(); rst = 1'b0;
        total++; if ({ovf, unf} !== 2'b00) begin bad++; $display("FAIL flg_reset got=%b exp=00", {ovf, unf}); end
        ld = 1'b1; ld_val = 4'd9; step(); ld = 1'b0;
        en = 1'b1; up = 1'b1; step();
        total++; if ({ovf, unf} !== 2'b10) begin bad++; $display("FAIL flg_ovf got=%b exp=10", {ovf, unf}); end
        en = 1'b0; step(); step();
        total++; if ({ovf, unf} !== 2'b10) begin bad++; $display("FAIL flg_persist got=%b exp=10", {ovf, unf}); end
        en = 1'b1; up = 1'b0; clr_flg = 1'b1; step();
        total++; if ({ovf, unf} !== 2'b01) begin bad++; $display("FAIL flg_clr_set got=%b exp=01", {ovf, unf}); end
        en = 1'b0; step();
        total++; if ({ovf, unf} !== 2'b00) begin bad++; $display("FAIL flg_clr got=%b exp=00", {ovf, unf}); end
        clr_flg = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load();
        test_reset_mid();
`ifdef UDC_STICKY_FLAGS_EN
        test_flags();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
